// File: rtl/mux_pkg.sv
// Shared types and constants for the registered N:1 select pipeline.
package mux_pkg;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} mux_pipe_state_t;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MUX_MAX_N = 16;

endpackage

// File: rtl/mux_n_1.sv
// Combinational WIDTH-bit N:1 selector; a select value of N or above yields zero.
module mux_n_1 #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned N     = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] din,
  output logic [WIDTH-1:0]   dout
);

  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) dout = din[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N:1 select followed by a registered valid/ready stage with a 2-entry skid buffer.
// Define MUX_N_PIPE_SEL_ERR_EN to add the sticky SEL_ERR out-of-range flag.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH = DATA_W,
  parameter  int unsigned N     = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               FLUSH,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [SEL_W-1:0]   SEL,
  input  logic [N*WIDTH-1:0] DIN,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [WIDTH-1:0]   OUT,
`ifdef MUX_N_PIPE_SEL_ERR_EN
  output logic               SEL_ERR,
`endif
  output logic [SEL_W-1:0]   SEL_Q
);

  mux_pipe_state_t state, next_state;

  logic             in_ready_q;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] main_d, skid_d;
  logic [SEL_W-1:0] main_s, skid_s;
  logic             accept, deliver;
  logic             load_main, load_skid, move_skid;

  mux_n_1 #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_sel (
    .sel  (SEL),
    .din  (DIN),
    .dout (sel_data)
  );

  assign OUT_VALID = (state != EMPTY);
  assign IN_READY  = in_ready_q;
  assign OUT       = main_d;
  assign SEL_Q     = main_s;

  assign accept  = IN_VALID & in_ready_q;
  assign deliver = OUT_VALID & OUT_READY;

  always_comb begin
    next_state = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    if (FLUSH) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_main  = 1'b1;
            next_state = ONE;
          end
        end
        ONE: begin
          if (deliver && accept) begin
            load_main = 1'b1;
          end else if (deliver) begin
            next_state = EMPTY;
          end else if (accept) begin
            load_skid  = 1'b1;
            next_state = FULL;
          end
        end
        FULL: begin
          if (deliver) begin
            move_skid  = 1'b1;
            next_state = ONE;
          end
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  // Data registers keep stale contents on flush; only the state (valids) clears.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      main_d     <= '0;
      main_s     <= '0;
      skid_d     <= '0;
      skid_s     <= '0;
    end else begin
      state      <= next_state;
      in_ready_q <= (next_state != FULL);
      if (load_main) begin
        main_d <= sel_data;
        main_s <= SEL;
      end else if (move_skid) begin
        main_d <= skid_d;
        main_s <= skid_s;
      end
      if (load_skid) begin
        skid_d <= sel_data;
        skid_s <= SEL;
      end
    end
  end

`ifdef MUX_N_PIPE_SEL_ERR_EN
  logic sel_oor;
  assign sel_oor = (32'(SEL) >= N);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SEL_ERR <= 1'b0;
    end else if (FLUSH) begin
      SEL_ERR <= 1'b0;
    end else if (accept && sel_oor) begin
      SEL_ERR <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: occupancy/queue model for N=4 plus directed literal checks, and an N=3 instance.
module tb_mux_n_pipe;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   sel;
  logic [127:0] din;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  dout;
  logic [1:0]   sel_q;

  logic         c3_flush;
  logic         c3_in_valid;
  logic         c3_in_ready;
  logic [1:0]   c3_sel;
  logic [95:0]  c3_din;
  logic         c3_out_valid;
  logic [31:0]  c3_dout;
  logic [1:0]   c3_sel_q;
`ifdef MUX_N_PIPE_SEL_ERR_EN
  logic         sel_err;
  logic         c3_sel_err;
`endif

  int total = 0;
  int bad   = 0;

  mux_n_pipe #(.WIDTH(32), .N(4)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .FLUSH     (flush),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .SEL       (sel),
    .DIN       (din),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT       (dout),
`ifdef MUX_N_PIPE_SEL_ERR_EN
    .SEL_ERR   (sel_err),
`endif
    .SEL_Q     (sel_q)
  );

  mux_n_pipe #(.WIDTH(32), .N(3)) dut3 (
    .CLK       (clk),
    .RST_N     (rst_n),
    .FLUSH     (c3_flush),
    .IN_VALID  (c3_in_valid),
    .IN_READY  (c3_in_ready),
    .SEL       (c3_sel),
    .DIN       (c3_din),
    .OUT_VALID (c3_out_valid),
    .OUT_READY (1'b1),
    .OUT       (c3_dout),
`ifdef MUX_N_PIPE_SEL_ERR_EN
    .SEL_ERR   (c3_sel_err),
`endif
    .SEL_Q     (c3_sel_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sel_val(input logic [127:0] d, input logic [1:0] s, input int n);
    if (int'(s) >= n) return 32'h0;
    return d[s*32 +: 32];
  endfunction

  function automatic logic [127:0] pat(input int k);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = {8'(k), 8'(i), 16'hC0DE};
    return r;
  endfunction

  // Model: a FIFO of at most two transfers; the head is what OUT shows.
  typedef struct { logic [31:0] d; logic [1:0] s; } ent_t;
  ent_t        q[$];
  logic [31:0] held_d;
  logic [1:0]  held_s;
  int          n_deliv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      held_d  = '0;
      held_s  = '0;
      n_deliv = 0;
    end else begin
      automatic bit m_acc = in_valid && (q.size() < 2);
      automatic bit m_del = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (m_del) begin
          void'(q.pop_front());
          n_deliv++;
        end
        if (m_acc) q.push_back('{d: sel_val(din, sel, 4), s: sel});
      end
      if (q.size() > 0) begin
        held_d = q[0].d;
        held_s = q[0].s;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("model_in_ready",  64'(in_ready),  64'(q.size() < 2));
      chk("model_out",       64'(dout),      64'(held_d));
      chk("model_sel_q",     64'(sel_q),     64'(held_s));
    end
  end

  task automatic step(input logic v, input logic [1:0] s, input logic [127:0] d,
                      input logic ordy, input logic fl);
    in_valid  = v;
    sel       = s;
    din       = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] DINA = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};

  initial begin
    int d0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; sel = '0; din = '0; out_ready = 1'b0;
    c3_flush = 1'b0; c3_in_valid = 1'b0; c3_sel = '0;
    c3_din = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out",       64'(dout),      64'd0);
    chk("rst_sel_q",     64'(sel_q),     64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // single transfer
    step(1, 2'd2, DINA, 1, 0);
    chk("single_out",       64'(dout),      64'hCCCC_CCCC);
    chk("single_sel_q",     64'(sel_q),     64'd2);
    chk("single_valid",     64'(out_valid), 64'd1);
    chk("single_in_ready",  64'(in_ready),  64'd1);
    step(0, 2'd0, DINA, 1, 0);
    chk("single_drained",   64'(out_valid), 64'd0);

    // backpressure into skid
    step(1, 2'd0, DINA, 0, 0);
    step(1, 2'd1, DINA, 0, 0);
    chk("bp_in_ready",  64'(in_ready),  64'd0);
    chk("bp_out",       64'(dout),      64'hAAAA_AAAA);
    step(1, 2'd2, DINA, 0, 0);
    chk("bp_held",      64'(dout),      64'hAAAA_AAAA);
    step(0, 2'd0, DINA, 1, 0);
    chk("bp_second",    64'(dout),      64'hBBBB_BBBB);
    chk("bp_sel_q",     64'(sel_q),     64'd1);
    chk("bp_ready_back",64'(in_ready),  64'd1);
    step(0, 2'd0, DINA, 1, 0);
    chk("bp_empty",     64'(out_valid), 64'd0);

    // streaming
    d0 = n_deliv;
    for (int k = 0; k < 20; k++) step(1, 2'(k % 4), pat(k), 1, 0);
    chk("stream_last", 64'(dout), 64'h1303_C0DE);
    step(0, 2'd0, '0, 1, 0);
    chk("stream_count", 64'(n_deliv - d0), 64'd20);

    // flush from FULL with a concurrent input
    step(1, 2'd0, DINA, 0, 0);
    step(1, 2'd1, DINA, 0, 0);
    step(1, 2'd3, DINA, 0, 1);
    chk("flush_valid",    64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready),  64'd1);
    chk("flush_stale",    64'(dout),      64'hAAAA_AAAA);
    step(0, 2'd0, DINA, 1, 0);
    chk("flush_dropped",  64'(out_valid), 64'd0);

    // out-of-range select on the N=3 instance
    c3_in_valid = 1'b1; c3_sel = 2'd3;
    @(posedge clk); #1;
    chk("oor_valid", 64'(c3_out_valid), 64'd1);
    chk("oor_out",   64'(c3_dout),      64'd0);
    chk("oor_sel_q", 64'(c3_sel_q),     64'd3);
    c3_sel = 2'd2;
    @(posedge clk); #1;
    chk("n3_sel2_out", 64'(c3_dout), 64'h3333_0002);
`ifdef MUX_N_PIPE_SEL_ERR_EN
    chk("sel_err_sticky", 64'(c3_sel_err), 64'd1);
    chk("sel_err_n4",     64'(sel_err),    64'd0);
`endif
    c3_in_valid = 1'b0; c3_flush = 1'b1;
    @(posedge clk); #1;
    c3_flush = 1'b0;
    chk("n3_flush_valid", 64'(c3_out_valid), 64'd0);
`ifdef MUX_N_PIPE_SEL_ERR_EN
    chk("sel_err_cleared", 64'(c3_sel_err), 64'd0);
`endif

    // async reset while FULL, with IN_VALID held through reset
    step(1, 2'd0, DINA, 0, 0);
    step(1, 2'd1, DINA, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",    64'(out_valid), 64'd0);
    chk("arst_out",      64'(dout),      64'd0);
    chk("arst_sel_q",    64'(sel_q),     64'd0);
    chk("arst_in_ready", 64'(in_ready),  64'd1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_ignored_in", 64'(out_valid), 64'd0);
    step(1, 2'd3, DINA, 1, 0);
    chk("arst_resume", 64'(dout), 64'hDDDD_DDDD);
    step(0, 2'd0, DINA, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
